out_port_buffer: RTL and testbench

Output-port buffer that sits directly downstream of the 8-bit pipelined CPU core (`cpu_top`). It captures each value the core writes to its output port, holds the values in order, and hands them to a consumer (UART transmitter, LED driver or bench monitor) over a valid/ready handshake. The block absorbs bursts of OUT instructions while the consumer stalls, and flags any writes lost because the buffer was full.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/out_buf_ram.sv | 29 ++
 rtl/out_port_buffer.sv | 111 +++++++++++
 tb/tb_out_port_buffer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath width and output-buffer defaults used by
// cpu_top and out_port_buffer, plus the per-cycle buffer operation type.
package cpu_pkg;

    localparam int DATA_W        = 8;
    localparam int OUT_BUF_DEPTH = 8;

    // Operation the buffer performs in one cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

endpackage

// File: rtl/out_buf_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port, no reset.
module out_buf_ram #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write of the pushed value.
    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_buffer.sv
// Output-port buffer behind cpu_top: captures core OUT writes in a circular
// buffer and presents them show-ahead on a valid/ready interface, with a
// sticky flag for writes lost while full.
module out_port_buffer #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::OUT_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    import cpu_pkg::*;

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              ovf_q,    ovf_d;

    logic              push, pop, drop;
    buf_op_e           op;
    logic [DATA_W-1:0] ram_rdata;

    // A full buffer still accepts a write when its head drains the same cycle.
    assign pop  = !empty_q && rd_ready;
    assign push = wr_en && (!full_q || pop);
    assign drop = wr_en && full_q && !pop;
    assign op   = buf_op_e'({push, pop});

    // Next-state pointers, occupancy and flags.
    // NOTE: every _d gets a default first so no path through the case can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unique case (op)
            BUF_PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            BUF_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            BUF_BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    // State registers; pointers wrap naturally at DEPTH (power of two).
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    out_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign rd_valid = !empty_q;
    assign rd_data  = rd_valid ? ram_rdata : '0;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_out_port_buffer.sv
// Self-checking bench for out_port_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_out_port_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr_ovf;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: ordered contents plus the sticky overflow flag.
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf;

    out_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string where);
        int sz;
        sz = mq.size();
        check({where, ".count"},    32'(count),    32'(sz));
        check({where, ".full"},     32'(full),     32'(sz == DEPTH));
        check({where, ".empty"},    32'(empty),    32'(sz == 0));
        check({where, ".rd_valid"}, 32'(rd_valid), 32'(sz != 0));
        check({where, ".rd_data"},  32'(rd_data),  (sz != 0) ? 32'(mq[0]) : 32'd0);
        check({where, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    function automatic void model_update(input logic w, input logic [DATA_W-1:0] d,
                                         input logic r, input logic c);
        bit pop_m, drop_m;
        pop_m  = (mq.size() != 0) && r;
        drop_m = w && (mq.size() == DEPTH) && !pop_m;
        if (pop_m) void'(mq.pop_front());
        if (w && !drop_m) mq.push_back(d);
        if (drop_m) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
    endfunction

    // One clock: drive at negedge, model follows the edge, compare at next negedge.
    task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d,
                        input logic r, input logic c);
        wr_en = w; wr_data = d; rd_ready = r; clr_ovf = c;
        @(posedge clk);
        model_update(w, d, r, c);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        // Three writes held, then drained in order.
        step("w3", 1'b1, 8'h11, 1'b0, 1'b0);
        step("w3", 1'b1, 8'h22, 1'b0, 1'b0);
        step("w3", 1'b1, 8'h33, 1'b0, 1'b0);
        check("w3.count_const", 32'(count), 32'd3);
        check("w3.head_const", 32'(rd_data), 32'h11);
        for (int i = 0; i < 3; i++) step("rd3", 1'b0, 8'h00, 1'b1, 1'b0);
        check("rd3.empty_const", 32'(empty), 32'd1);

        // Fill, then a dropped write sets overflow; clear it afterwards.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("drop", 1'b1, 8'hAA, 1'b0, 1'b0);
        check("drop.full_const", 32'(full), 32'd1);
        check("drop.ovf_const", 32'(overflow), 32'd1);
        check("drop.count_const", 32'(count), 32'd8);
        drain("drain_drop");
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("clr.ovf_const", 32'(overflow), 32'd0);

        // Full buffer accepts a write when it drains in the same cycle.
        for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step("full_both", 1'b1, 8'h55, 1'b1, 1'b0);
        check("full_both.count_const", 32'(count), 32'd8);
        check("full_both.ovf_const", 32'(overflow), 32'd0);
        drain("drain_both");

        // Twelve writes with interleaved pops wrap both pointers.
        for (int i = 0; i < 12; i++)
            step("wrap", 1'b1, 8'(8'h40 + i), (i % 3 == 2), 1'b0);

        // Drop and clear in the same cycle: set wins.
        step("drop_clr", 1'b1, 8'h99, 1'b0, 1'b1);
        check("drop_clr.ovf_const", 32'(overflow), 32'd1);
        step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
        drain("drain_wrap");

        // Asynchronous reset mid-burst with five entries held.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        check("pre_rst.count_const", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all("async_rst");
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 8'h7E, 1'b0, 1'b0);
        check("post_rst.head_const", 32'(rd_data), 32'h7E);
        drain("drain_rst");

        // Randomized traffic with varying write/read pressure.
        for (int phase = 0; phase < 12; phase++) begin
            int pw, pr, pc;
            pw = $urandom_range(20, 95);
            pr = $urandom_range(10, 95);
            pc = $urandom_range(0, 15);
            for (int i = 0; i < 200; i++)
                step("rand", ($urandom_range(0, 99) < pw), 8'($urandom),
                     ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
